// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: register index, FSM state,
// the stage enable/flush bundle and the no-hazard/branch/load-use output helper.
package pipe_ctrl_pkg;

  typedef logic [4:0] r_t;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StMemWait
  } pipe_state_t;

  localparam int unsigned DefaultTimeoutCycles = 256;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CtrlInit   = 9'b00000_1111;
  localparam stage_ctrl_t CtrlFreeze = 9'b00000_0000;
  localparam stage_ctrl_t CtrlRun    = 9'b11111_0000;

  // Normal advance; a taken branch squashes ID, so it outranks the load-use stall.
  function automatic stage_ctrl_t run_ctrl(input logic branch, input logic hazard);
    stage_ctrl_t c;
    c = CtrlRun;
    if (branch) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (hazard) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  r_t   id_rs1_i,
  input  r_t   id_rs2_i,
  input  logic id_use_rs1_i,
  input  logic id_use_rs2_i,
  input  r_t   ex_rd_i,
  input  logic ex_is_load_i,
  output logic hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard_o = ex_is_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables/flushes, stall counter and optional memory-wait
// watchdog (enabled by defining PIPE_CTRL_TIMEOUT_EN).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_is_load_i,
  input  logic        ex_branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_mem_en_o,
  output logic        mem_wb_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic        mem_wb_flush_o,
  output logic [31:0] stall_cnt_o,
  output logic        mem_timeout_o
);

  pipe_state_t state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  stage_ctrl_t ctrl;
  logic        hazard;
  logic        timeout_hit;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .ex_rd_i      (ex_rd_i),
    .ex_is_load_i (ex_is_load_i),
    .hazard_o     (hazard)
  );

`ifdef PIPE_CTRL_TIMEOUT_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        mem_timeout_q;

  // Held at zero outside MEM_WAIT, so it always starts from zero on entry.
  assign wd_cnt_d    = (state_q == StMemWait) ? wd_cnt_q + 32'd1 : '0;
  assign timeout_hit = (state_q == StMemWait) && !mem_ack_i &&
                       (wd_cnt_q == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      mem_timeout_q <= mem_timeout_q | timeout_hit;
    end
  end

  assign mem_timeout_o = mem_timeout_q;
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
  assign mem_timeout_o         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ctrl    = CtrlFreeze;
    unique case (state_q)
      StInit: begin
        ctrl    = CtrlInit;
        state_d = StRun;
      end
      StRun: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d = StMemWait;
        end else begin
          ctrl = run_ctrl(ex_branch_taken_i, hazard);
        end
      end
      StMemWait: begin
        if (mem_ack_i) begin
          ctrl    = run_ctrl(ex_branch_taken_i, hazard);
          state_d = StRun;
        end else if (timeout_hit) begin
          // Abandon the access: bubble the memory-side stages and resume.
          ctrl.ex_mem_flush = 1'b1;
          ctrl.mem_wb_flush = 1'b1;
          state_d           = StRun;
        end
      end
      default: state_d = StInit;
    endcase
  end

  assign stall_cnt_d = (!ctrl.pc_en && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StInit;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en_o        = ctrl.pc_en;
  assign if_id_en_o     = ctrl.if_id_en;
  assign id_ex_en_o     = ctrl.id_ex_en;
  assign ex_mem_en_o    = ctrl.ex_mem_en;
  assign mem_wb_en_o    = ctrl.mem_wb_en;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign ex_mem_flush_o = ctrl.ex_mem_flush;
  assign mem_wb_flush_o = ctrl.mem_wb_flush;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle queues its expected controls,
// stall count and timeout flag; the negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam int unsigned TimeoutCycles = 8;

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb flushes}
  localparam logic [8:0] ExpInit   = 9'b00000_1111;
  localparam logic [8:0] ExpRun    = 9'b11111_0000;
  localparam logic [8:0] ExpFreeze = 9'b00000_0000;
  localparam logic [8:0] ExpBr     = 9'b11111_1100;
  localparam logic [8:0] ExpLu     = 9'b00111_0100;
  localparam logic [8:0] ExpTo     = 9'b00000_0011;

  typedef struct {
    string       tag;
    logic [8:0]  ctrl;
    logic [31:0] cnt;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic        ex_is_load = 1'b0, ex_branch_taken = 1'b0;
  logic        mem_req = 1'b0, mem_ack = 1'b0;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [31:0] stall_cnt;
  logic        mem_timeout;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cnt = '0;
  logic        exp_tmo = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_to = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_use_rs1_i      (id_use_rs1),
    .id_use_rs2_i      (id_use_rs2),
    .ex_rd_i           (ex_rd),
    .ex_is_load_i      (ex_is_load),
    .ex_branch_taken_i (ex_branch_taken),
    .mem_req_i         (mem_req),
    .mem_ack_i         (mem_ack),
    .pc_en_o           (pc_en),
    .if_id_en_o        (if_id_en),
    .id_ex_en_o        (id_ex_en),
    .ex_mem_en_o       (ex_mem_en),
    .mem_wb_en_o       (mem_wb_en),
    .if_id_flush_o     (if_id_flush),
    .id_ex_flush_o     (id_ex_flush),
    .ex_mem_flush_o    (ex_mem_flush),
    .mem_wb_flush_o    (mem_wb_flush),
    .stall_cnt_o       (stall_cnt),
    .mem_timeout_o     (mem_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_eq({mon_e.tag, ".ctrl"},
               {23'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush},
               {23'd0, mon_e.ctrl});
      check_eq({mon_e.tag, ".stall_cnt"}, stall_cnt, mon_e.cnt);
      check_eq({mon_e.tag, ".mem_timeout"}, {31'd0, mem_timeout}, {31'd0, mon_e.tmo});
    end
  end

  // One clock of stimulus; the expected stall count reflects every earlier pc_en = 0 cycle.
  task automatic cyc(input string tag, input logic [8:0] exp, input logic ld,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic br,
                     input logic req, input logic ack);
    @(posedge clk);
    if (prev_stall) exp_cnt++;
    if (prev_to) exp_tmo = 1'b1;
    #1;
    ex_is_load = ld; ex_rd = rd; id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2; id_use_rs2 = u2; ex_branch_taken = br;
    mem_req = req; mem_ack = ack;
    sb_q.push_back('{tag, exp, exp_cnt, exp_tmo});
    prev_stall = !exp[8];
    prev_to    = (exp == ExpTo);
  endtask

  task automatic idle(input string tag);
    cyc(tag, ExpRun, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ex_is_load = 1'b0; ex_rd = '0; id_rs1 = '0; id_use_rs1 = 1'b0;
    id_rs2 = '0; id_use_rs2 = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
    exp_cnt = '0; exp_tmo = 1'b0; prev_stall = 1'b0; prev_to = 1'b0;
    sb_q.push_back('{{tag, "_assert"}, ExpInit, 32'd0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.push_back('{{tag, "_init"}, ExpInit, 32'd0, 1'b0});
    prev_stall = 1'b1;
  endtask

  initial begin
    do_reset("rst");
    idle("rst_run");

    cyc("lu_rs1", ExpLu, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("lu_rs1_after");
    cyc("lu_rs2", ExpLu, 1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_rd0", ExpRun, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_unused", ExpRun, 1'b1, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_noload", ExpRun, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    cyc("br_lu", ExpBr, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("br_only", ExpBr, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("br_after");

    for (int i = 0; i < 4; i++)
      cyc("mw_wait", ExpFreeze, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mw_ack", ExpRun, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("mw_zero", ExpRun, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("mw_after");

    for (int i = 0; i < 3; i++)
      cyc("mwbr_wait", ExpFreeze, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("mwbr_ack", ExpBr, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle("mwbr_after");

    cyc("mwlu_wait", ExpFreeze, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mwlu_ack", ExpLu, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("mwlu_after");

    cyc("mwrst_wait", ExpFreeze, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mwrst_wait", ExpFreeze, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset("mwrst");
    idle("mwrst_run");

`ifdef PIPE_CTRL_TIMEOUT_EN
    for (int i = 0; i < 8; i++)
      cyc("wd_wait", ExpFreeze, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("wd_fire", ExpTo, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("wd_run");
    idle("wd_sticky");
    do_reset("wd_rst");
    idle("wd_clear");
`endif

    @(posedge clk);
    @(negedge clk);
    check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
